tuser_capture_sched: RTL and testbench

- Frame-synchronous capture scheduler on the tp_clk AXI-Stream side.
- Arms on a command, waits for start-of-frame (tuser on an accepted beat), then opens a capture window for N whole frames.
- Measures each frame's length in beats, checks it against an expected length, and aborts on a stalled stream via a watchdog.
- Drives the window/status that the capture datapath and the CDC peek logic consume.

---
 rtl/tuser_capture_sched.sv | 172 +++++++++++++++++
 tb/tb_tuser_capture_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tuser_capture_sched.sv
// Frame-synchronous capture scheduler: arms, waits for SOF, opens a window for N frames,
// checks frame length and guards against stalled streams. Optional stats via TUSER_SCHED_STATS_EN.
module tuser_capture_sched #(
  parameter int unsigned CWIDTH      = 10,
  parameter int unsigned FWIDTH      = 8,
  parameter int unsigned TWIDTH      = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic              tp_clk,
  input  logic              tp_rst,
  input  logic              tp_tuser,
  input  logic              tp_tvalid_and_tready,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [FWIDTH-1:0] frame_count_i,
  input  logic [CWIDTH-1:0] expected_len_i,
  output logic              window_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              len_error_o,
  output logic              overflow_o,
  output logic [FWIDTH-1:0] frames_done_o,
  output logic [CWIDTH-1:0] last_len_o,
  output logic [CWIDTH-1:0] min_len_o,
  output logic [CWIDTH-1:0] max_len_o
);

  typedef enum logic [2:0] {StIdle, StArmed, StCapture, StDone, StErr} state_e;

  localparam logic [TWIDTH-1:0] WdogLast = TWIDTH'(TIMEOUT_CYC - 1);

  state_e            state_q;
  logic [CWIDTH-1:0] beat_q, exp_q, last_len_q;
  logic [FWIDTH-1:0] count_q, frames_q, frames_inc;
  logic [TWIDTH-1:0] wdog_q;
  logic              busy_q, done_q, timeout_q, len_err_q, ovf_q;
  logic              sof, last_frame, wdog_hit, arm_take, frame_end;

  assign sof        = tp_tuser & tp_tvalid_and_tready;
  assign frames_inc = frames_q + 1'b1;
  assign last_frame = (count_q != '0) && (frames_inc == count_q);
  // A cycle without SOF at this count is the one that trips the watchdog.
  assign wdog_hit   = (wdog_q >= WdogLast);
  assign arm_take   = arm_i && !abort_i &&
                      ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign frame_end  = sof && !abort_i && (state_q == StCapture);

  always_comb begin
    window_o = 1'b0;
    case (state_q)
      StArmed:   window_o = sof;
      StCapture: window_o = tp_tvalid_and_tready && !(sof && last_frame);
      default:   window_o = 1'b0;
    endcase
  end

  always_ff @(posedge tp_clk or posedge tp_rst) begin
    if (tp_rst) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      len_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      beat_q     <= '0;
      exp_q      <= '0;
      last_len_q <= '0;
      count_q    <= '0;
      frames_q   <= '0;
      wdog_q     <= '0;
    end else if (abort_i) begin
      // Abort keeps sticky flags and counts for post-mortem inspection.
      state_q <= StIdle;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone, StErr: begin
          if (arm_take) begin
            state_q    <= StArmed;
            busy_q     <= 1'b1;
            count_q    <= frame_count_i;
            exp_q      <= expected_len_i;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            len_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
            frames_q   <= '0;
            last_len_q <= '0;
            beat_q     <= '0;
            wdog_q     <= '0;
          end
        end
        StArmed: begin
          if (sof) begin
            state_q <= StCapture;
            beat_q  <= CWIDTH'(1);
            wdog_q  <= '0;
          end else if (wdog_hit) begin
            state_q   <= StErr;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StCapture: begin
          if (frame_end) begin
            last_len_q <= beat_q;
            frames_q   <= frames_inc;
            if ((exp_q != '0) && (beat_q != exp_q)) len_err_q <= 1'b1;
            beat_q <= CWIDTH'(1);
            wdog_q <= '0;
            if (last_frame) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            if (tp_tvalid_and_tready) begin
              if (&beat_q) ovf_q <= 1'b1;
              else         beat_q <= beat_q + 1'b1;
            end
            if (wdog_hit) begin
              state_q   <= StErr;
              busy_q    <= 1'b0;
              timeout_q <= 1'b1;
            end else begin
              wdog_q <= wdog_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign len_error_o   = len_err_q;
  assign overflow_o    = ovf_q;
  assign frames_done_o = frames_q;
  assign last_len_o    = last_len_q;

`ifdef TUSER_SCHED_STATS_EN
  logic [CWIDTH-1:0] min_q, max_q;

  always_ff @(posedge tp_clk or posedge tp_rst) begin
    if (tp_rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (arm_take) begin
      min_q <= '1;
      max_q <= '0;
    end else if (frame_end) begin
      if (beat_q < min_q) min_q <= beat_q;
      if (beat_q > max_q) max_q <= beat_q;
    end
  end

  assign min_len_o = min_q;
  assign max_len_o = max_q;
`else
  assign min_len_o = '0;
  assign max_len_o = '0;
`endif

endmodule

// File: tb/tb_tuser_capture_sched.sv
// Scoreboard bench for tuser_capture_sched: stimulus pushes expected window bits and status
// snapshots; a negedge monitor pops and compares them.
module tb_tuser_capture_sched;

  localparam int unsigned CW   = 10;
  localparam int unsigned FW   = 8;
  localparam int unsigned TMO  = 1100;
  localparam int unsigned ALL1 = 1023;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          tmo;
    logic          lerr;
    logic          ovf;
    logic [FW-1:0] frames;
    logic [CW-1:0] last;
    logic [CW-1:0] mn;
    logic [CW-1:0] mx;
  } st_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tuser = 1'b0;
  logic          tvr = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] frame_count = '0;
  logic [CW-1:0] expected_len = '0;
  logic          window, busy, done, timeout, len_error, overflow;
  logic [FW-1:0] frames_done;
  logic [CW-1:0] last_len, min_len, max_len;

  int checks = 0;
  int errors = 0;

  logic win_q[$];
  st_t  st_q[$];

  tuser_capture_sched #(
    .CWIDTH     (CW),
    .FWIDTH     (FW),
    .TWIDTH     (16),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .tp_clk              (clk),
    .tp_rst              (rst),
    .tp_tuser            (tuser),
    .tp_tvalid_and_tready(tvr),
    .arm_i               (arm),
    .abort_i             (abort),
    .frame_count_i       (frame_count),
    .expected_len_i      (expected_len),
    .window_o            (window),
    .busy_o              (busy),
    .done_o              (done),
    .timeout_o           (timeout),
    .len_error_o         (len_error),
    .overflow_o          (overflow),
    .frames_done_o       (frames_done),
    .last_len_o          (last_len),
    .min_len_o           (min_len),
    .max_len_o           (max_len)
  );

  always #5 clk = ~clk;

  st_t act_s, exp_s;
  logic exp_w;

  always @(negedge clk) begin
    if (tvr) begin
      checks++;
      if (win_q.size() == 0) begin
        errors++;
        $display("FAIL window: beat with no expectation, window=%b", window);
      end else begin
        exp_w = win_q.pop_front();
        if (window !== exp_w) begin
          errors++;
          $display("FAIL window at %0t: got %b want %b", $time, window, exp_w);
        end
      end
    end
    while (st_q.size() != 0) begin
      exp_s = st_q.pop_front();
      act_s = {busy, done, timeout, len_error, overflow, frames_done, last_len, min_len, max_len};
      checks++;
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL status at %0t: got b%b d%b t%b l%b o%b fr=%0d last=%0d min=%0d max=%0d want b%b d%b t%b l%b o%b fr=%0d last=%0d min=%0d max=%0d",
                 $time, act_s.busy, act_s.done, act_s.tmo, act_s.lerr, act_s.ovf, act_s.frames,
                 act_s.last, act_s.mn, act_s.mx, exp_s.busy, exp_s.done, exp_s.tmo, exp_s.lerr,
                 exp_s.ovf, exp_s.frames, exp_s.last, exp_s.mn, exp_s.mx);
      end
    end
  end

  task automatic cyc(input logic tu, input logic v, input logic ew);
    tuser = tu;
    tvr   = v;
    if (v) win_q.push_back(ew);
    @(posedge clk);
    #1;
    tuser = 1'b0;
    tvr   = 1'b0;
    arm   = 1'b0;
    abort = 1'b0;
  endtask

  task automatic chk(input logic b, input logic d, input logic t, input logic l, input logic o,
                     input int fr, input int last, input int mn, input int mx);
    st_t s;
    s.busy = b; s.done = d; s.tmo = t; s.lerr = l; s.ovf = o;
    s.frames = FW'(fr);
    s.last   = CW'(last);
`ifdef TUSER_SCHED_STATS_EN
    s.mn = CW'(mn);
    s.mx = CW'(mx);
`else
    s.mn = '0;
    s.mx = '0;
`endif
    st_q.push_back(s);
  endtask

  task automatic do_arm(input int cnt, input int exp_len);
    arm          = 1'b1;
    frame_count  = FW'(cnt);
    expected_len = CW'(exp_len);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    chk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);

    // Three 100-beat frames, window closes on the terminating SOF
    do_arm(3, 100);
    chk(1, 0, 0, 0, 0, 0, 0, ALL1, 0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int b = 0; b <= 300; b++) cyc((b % 100) == 0, 1'b1, b < 300);
    chk(0, 1, 0, 0, 0, 3, 100, 100, 100);
    cyc(1'b0, 1'b0, 1'b0);

    // Second frame short by one beat
    do_arm(3, 100);
    for (int b = 0; b <= 299; b++) cyc(b == 0 || b == 100 || b == 199 || b == 299, 1'b1, b < 299);
    chk(0, 1, 0, 1, 0, 3, 100, 99, 100);
    cyc(1'b0, 1'b0, 1'b0);

    // Watchdog: no SOF for TMO cycles
    do_arm(1, 0);
    for (int i = 0; i < int'(TMO) - 1; i++) cyc(1'b0, 1'b0, 1'b0);
    chk(1, 0, 0, 0, 0, 0, 0, ALL1, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk(0, 0, 1, 0, 0, 0, 0, ALL1, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // SOF exactly on the tripping cycle wins
    do_arm(1, 0);
    for (int i = 0; i < int'(TMO) - 1; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk(1, 0, 0, 0, 0, 0, 0, ALL1, 0);
    cyc(1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk(0, 0, 0, 0, 0, 0, 0, ALL1, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // Continuous mode, five 20-beat frames, then abort
    do_arm(0, 20);
    for (int b = 0; b <= 100; b++) cyc((b % 20) == 0, 1'b1, 1'b1);
    abort = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk(0, 0, 0, 0, 0, 5, 20, 20, 20);
    cyc(1'b0, 1'b0, 1'b0);

    // arm and abort together from IDLE: abort wins, counts held
    abort = 1'b1;
    do_arm(7, 3);
    chk(0, 0, 0, 0, 0, 5, 20, 20, 20);
    cyc(1'b0, 1'b0, 1'b0);

    // arm during CAPTURE is ignored
    do_arm(2, 10);
    for (int b = 0; b <= 20; b++) begin
      if (b == 5) begin
        arm          = 1'b1;
        frame_count  = '0;
        expected_len = '0;
      end
      cyc((b % 10) == 0, 1'b1, b < 20);
    end
    chk(0, 1, 0, 0, 0, 2, 10, 10, 10);
    cyc(1'b0, 1'b0, 1'b0);

    // Beat counter saturation on a 1030-beat frame
    do_arm(1, 0);
    for (int b = 0; b <= 1030; b++) cyc(b == 0 || b == 1030, 1'b1, b < 1030);
    chk(0, 1, 0, 0, 1, 1, ALL1, ALL1, ALL1);
    cyc(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-capture
    do_arm(0, 0);
    for (int b = 0; b < 10; b++) cyc(b == 0, 1'b1, 1'b1);
    tvr = 1'b1;
    #1;
    rst = 1'b1;
    chk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    win_q.push_back(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    chk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (win_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d window / %0d status left, want 0 / 0", win_q.size(),
               st_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
